// File: rtl/fft_frame_sched.sv
// fft_frame_sched: loads a frame into the FFT, launches it, streams bins to the decoder, then waits for the note decision or a timeout
module fft_frame_sched #(
  parameter int BIT_WIDTH   = 16,
  parameter int N           = 9,
  parameter int FFT_SIZE    = 512,
  parameter int DEC_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic [BIT_WIDTH-1:0]   sample_in,
  output logic                   fft_load,
  output logic [N-1:0]           fft_load_addr,
  output logic [BIT_WIDTH-1:0]   fft_load_data,
  output logic                   fft_start,
  input  logic                   fft_done,
  output logic [N-1:0]           fft_rd_addr,
  input  logic [2*BIT_WIDTH-1:0] fft_rd_data,
  output logic                   bin_valid,
  output logic [2*BIT_WIDTH-1:0] bin_data,
  output logic                   bin_last,
  input  logic                   note_dec,
  output logic                   sample_drop,
  output logic                   dec_timeout,
  output logic                   busy,
  output logic [15:0]            frame_count
);
  localparam int TW = $clog2(DEC_TIMEOUT + 1);
  typedef enum logic [2:0] {LOAD, START, WAIT_FFT, READ, WAIT_DEC} state_t;
  state_t state_q, state_d;
  logic [N-1:0] load_cnt_q, load_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic bin_valid_q, bin_valid_d, bin_last_q, bin_last_d;
  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    tmo_cnt_d     = '0;
    frame_count_d = frame_count_q;
    fft_load      = 1'b0;
    dec_timeout   = 1'b0;
    fft_start     = state_q == START;
    sample_drop   = sample_valid && state_q != LOAD;
    bin_valid_d   = state_q == READ;
    bin_last_d    = state_q == READ && rd_cnt_q == N'(FFT_SIZE - 1);
    case (state_q)
      LOAD: if (sample_valid) begin
        fft_load   = 1'b1;
        load_cnt_d = load_cnt_q + N'(1);
        if (load_cnt_q == N'(FFT_SIZE - 1)) begin
          load_cnt_d = '0;
          state_d    = START;
        end
      end
      START: state_d = WAIT_FFT;
      WAIT_FFT: if (fft_done) begin
        rd_cnt_d = '0;
        state_d  = READ;
      end
      READ: begin
        rd_cnt_d = rd_cnt_q + N'(1);
        if (rd_cnt_q == N'(FFT_SIZE - 1)) begin
          rd_cnt_d = '0;
          state_d  = WAIT_DEC;
        end
      end
      WAIT_DEC: begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        if (note_dec || tmo_cnt_q == TW'(DEC_TIMEOUT - 1)) begin
          tmo_cnt_d     = '0;
          frame_count_d = frame_count_q + 16'd1;
          dec_timeout   = !note_dec;
          state_d       = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= LOAD;
      load_cnt_q    <= '0;
      rd_cnt_q      <= '0;
      tmo_cnt_q     <= '0;
      frame_count_q <= '0;
      bin_valid_q   <= 1'b0;
      bin_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      frame_count_q <= frame_count_d;
      bin_valid_q   <= bin_valid_d;
      bin_last_q    <= bin_last_d;
    end
  end
  assign fft_load_addr = fft_load ? load_cnt_q : '0;
  assign fft_load_data = fft_load ? sample_in : '0;
  assign fft_rd_addr   = rd_cnt_q;
  assign bin_valid     = bin_valid_q;
  assign bin_last      = bin_last_q;
  assign bin_data      = bin_valid_q ? fft_rd_data : '0;
  assign busy          = state_q != LOAD;
  assign frame_count   = frame_count_q;
endmodule

// File: tb/tb_fft_frame_sched.sv
// tb_fft_frame_sched: directed self-checking bench for fft_frame_sched
module tb_fft_frame_sched;
  localparam int BW = 16, N = 9, FS = 512, DT = 1024;
  logic clk = 1'b0, reset = 1'b0, sample_valid = 1'b0, fft_done = 1'b0, note_dec = 1'b0;
  logic [BW-1:0] sample_in = '0;
  logic [2*BW-1:0] fft_rd_data;
  logic fft_load, fft_start, bin_valid, bin_last, sample_drop, dec_timeout, busy;
  logic [N-1:0] fft_load_addr, fft_rd_addr;
  logic [BW-1:0] fft_load_data;
  logic [2*BW-1:0] bin_data;
  logic [15:0] frame_count;
  int vectors = 0, miscompares = 0;
  fft_frame_sched #(.BIT_WIDTH(BW), .N(N), .FFT_SIZE(FS), .DEC_TIMEOUT(DT)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .fft_load(fft_load), .fft_load_addr(fft_load_addr), .fft_load_data(fft_load_data),
    .fft_start(fft_start), .fft_done(fft_done), .fft_rd_addr(fft_rd_addr),
    .fft_rd_data(fft_rd_data), .bin_valid(bin_valid), .bin_data(bin_data),
    .bin_last(bin_last), .note_dec(note_dec), .sample_drop(sample_drop),
    .dec_timeout(dec_timeout), .busy(busy), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) fft_rd_data <= {BW'(fft_rd_addr), ~BW'(fft_rd_addr)};
  task automatic step;
    @(negedge clk);
  endtask
  task automatic test_reset;
    step;
    step;
    #1;
    vectors++;
    if ({fft_load, fft_load_addr, fft_load_data, fft_start, fft_rd_addr, bin_valid, bin_data, bin_last, sample_drop, dec_timeout, busy, frame_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs load=%b la=%0h ld=%0h st=%b ra=%0h bv=%b bd=%0h bl=%b sd=%b dt=%b busy=%b fc=%0d, all required 0",
               fft_load, fft_load_addr, fft_load_data, fft_start, fft_rd_addr, bin_valid, bin_data, bin_last, sample_drop, dec_timeout, busy, frame_count);
    end
    step;
    reset = 1'b1;
  endtask
  task automatic load_frame(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      step;
      sample_valid = 1'b1;
      sample_in = BW'(base + i);
      #1;
      vectors++;
      if ({fft_load, fft_load_addr, fft_load_data, fft_start, busy} !== {1'b1, N'(i), BW'(base + i), 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL load[%0d] got load=%b addr=%0d data=%0h start=%b busy=%b, need 1 %0d %0h 0 0",
                 i, fft_load, fft_load_addr, fft_load_data, fft_start, busy, i, BW'(base + i));
      end
    end
  endtask
  task automatic test_start;
    step;
    sample_valid = 1'b0;
    fft_done = 1'b1;
    #1;
    vectors++;
    if ({fft_start, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL start_pulse got start=%b busy=%b, need 1 1", fft_start, busy);
    end
    step;
    fft_done = 1'b0;
    #1;
    vectors++;
    if ({fft_start, busy, bin_valid} !== 3'b010) begin
      miscompares++;
      $display("FAIL start_single got start=%b busy=%b bv=%b, need 0 1 0", fft_start, busy, bin_valid);
    end
  endtask
  task automatic test_wait_fft;
    for (int c = 0; c < 99; c++) begin
      if (c > 0) step;
      sample_valid = c < 10;
      #1;
      vectors++;
      if ({sample_drop, fft_load, bin_valid, busy} !== {c < 10, 1'b0, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL wait_fft[%0d] got drop=%b load=%b bv=%b busy=%b, need %b 0 0 1", c, sample_drop, fft_load, bin_valid, busy, c < 10);
      end
    end
    step;
    sample_valid = 1'b0;
    fft_done = 1'b1;
    step;
    fft_done = 1'b0;
    #1;
    vectors++;
    if ({bin_valid, fft_rd_addr} !== {1'b0, N'(0)}) begin
      miscompares++;
      $display("FAIL read_first_addr got bv=%b addr=%0d, need 0 0", bin_valid, fft_rd_addr);
    end
  endtask
  task automatic test_stream;
    for (int i = 0; i < FS; i++) begin
      step;
      #1;
      vectors++;
      if ({bin_valid, bin_data, bin_last, busy} !== {1'b1, BW'(i), ~BW'(i), i == FS - 1, 1'b1}) begin
        miscompares++;
        $display("FAIL bin[%0d] got bv=%b data=%0h last=%b busy=%b, need 1 %0h %b 1",
                 i, bin_valid, bin_data, bin_last, busy, {BW'(i), ~BW'(i)}, i == FS - 1);
      end
    end
  endtask
  task automatic test_note(input logic [15:0] exp_fc);
    for (int k = 0; k < 5; k++) begin
      step;
      note_dec = k == 4;
      #1;
      vectors++;
      if ({bin_valid, dec_timeout, busy} !== 3'b001) begin
        miscompares++;
        $display("FAIL wait_dec[%0d] got bv=%b tmo=%b busy=%b, need 0 0 1", k, bin_valid, dec_timeout, busy);
      end
    end
    step;
    note_dec = 1'b0;
    #1;
    vectors++;
    if ({busy, dec_timeout, frame_count} !== {2'b00, exp_fc}) begin
      miscompares++;
      $display("FAIL note_done got busy=%b tmo=%b fc=%0d, need 0 0 %0d", busy, dec_timeout, frame_count, exp_fc);
    end
  endtask
  task automatic test_timeout(input logic [15:0] exp_fc);
    for (int k = 2; k < DT; k++) begin
      step;
      #1;
      vectors++;
      if ({dec_timeout, busy} !== 2'b01) begin
        miscompares++;
        $display("FAIL tmo_early[%0d] got tmo=%b busy=%b, need 0 1", k, dec_timeout, busy);
      end
    end
    step;
    #1;
    vectors++;
    if ({dec_timeout, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL tmo_pulse got tmo=%b busy=%b, need 1 1", dec_timeout, busy);
    end
    step;
    #1;
    vectors++;
    if ({dec_timeout, busy, frame_count} !== {2'b00, exp_fc}) begin
      miscompares++;
      $display("FAIL tmo_after got tmo=%b busy=%b fc=%0d, need 0 0 %0d", dec_timeout, busy, frame_count, exp_fc);
    end
    step;
    sample_valid = 1'b1;
    sample_in = 16'h0abc;
    #1;
    vectors++;
    if ({fft_load, fft_load_addr, fft_load_data} !== {1'b1, N'(0), 16'h0abc}) begin
      miscompares++;
      $display("FAIL tmo_reload got load=%b addr=%0d data=%0h, need 1 0 abc", fft_load, fft_load_addr, fft_load_data);
    end
    step;
    sample_valid = 1'b0;
  endtask
  task automatic test_ignored;
    step;
    note_dec = 1'b1;
    fft_done = 1'b1;
    #1;
    vectors++;
    if ({busy, fft_start, dec_timeout} !== 3'b000) begin
      miscompares++;
      $display("FAIL ignored_in got busy=%b start=%b tmo=%b, need 0 0 0", busy, fft_start, dec_timeout);
    end
    step;
    note_dec = 1'b0;
    fft_done = 1'b0;
    #1;
    vectors++;
    if ({busy, fft_start, frame_count} !== {2'b00, 16'd2}) begin
      miscompares++;
      $display("FAIL ignored_after got busy=%b start=%b fc=%0d, need 0 0 2", busy, fft_start, frame_count);
    end
  endtask
  task automatic test_reset_mid;
    load_frame(300, 7);
    step;
    sample_valid = 1'b0;
    reset = 1'b0;
    #1;
    vectors++;
    if ({fft_load, fft_load_addr, fft_start, bin_valid, bin_data, bin_last, sample_drop, dec_timeout, busy, frame_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid got load=%b la=%0d st=%b bv=%b bd=%0h bl=%b sd=%b dt=%b busy=%b fc=%0d, all required 0",
               fft_load, fft_load_addr, fft_start, bin_valid, bin_data, bin_last, sample_drop, dec_timeout, busy, frame_count);
    end
    step;
    reset = 1'b1;
  endtask
  initial begin
    test_reset;
    load_frame(FS, 0);
    test_start;
    test_wait_fft;
    test_stream;
    test_note(16'd1);
    load_frame(FS, 1000);
    test_start;
    test_wait_fft;
    test_stream;
    test_note(16'd2);
    test_ignored;
    test_reset_mid;
    load_frame(FS, 2000);
    test_start;
    test_wait_fft;
    test_stream;
    test_timeout(16'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
